mmio_uart_tx: RTL and testbench

Memory-mapped console output stage sitting directly downstream of the core's data-memory write port, alongside `dmem`. It snoops `dmem_we`/`dmem_addr`/`dmem_wdata` from the pipeline, treats a store to address 0x0 as a console character and a store to 0x8 as the program-finish marker, buffers characters in a FIFO and serialises them as 8N1 UART frames on `txd`. It also drives an 8-bit status LED image and a drain-complete flag for the bench.

---
 rtl/mmio_uart_tx_if.sv | 22 ++
 rtl/mmio_uart_tx.sv | 235 +++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_if.sv
// Core data-memory store port as seen by the console output stage.
// The pipeline drives it (master); snoopers such as mmio_uart_tx listen (slave).
interface mmio_uart_tx_if #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
);
    logic                dmem_we;
    logic [ADDR_LEN-1:0] dmem_addr;
    logic [DATA_LEN-1:0] dmem_wdata;

    modport master (
        output dmem_we,
        output dmem_addr,
        output dmem_wdata
    );

    modport slave (
        input dmem_we,
        input dmem_addr,
        input dmem_wdata
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// MMIO console: stores to 0x0 queue a char, to 0x8 mark finish; chars leave as 8N1 on txd.
// MMIO_UART_TX_FIFO_EN selects a FIFO_DEPTH-entry FIFO, else a single holding register.
module mmio_uart_tx #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_LEN   = 32,
    parameter int DATA_LEN   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    mmio_uart_tx_if.slave        bus,
    output logic                 txd,
    output logic [7:0]           led,
    output logic                 finished,
    output logic                 done,
    output logic                 overflow
);

    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic       cw;
    logic       fw;
    logic       push;
    logic       pop;
    logic       q_empty;
    logic       q_full;
    logic [7:0] q_head;
    logic [7:0] wbyte;

    assign wbyte = bus.dmem_wdata[7:0];
    assign cw    = bus.dmem_we && (bus.dmem_addr == '0);
    assign fw    = bus.dmem_we && (bus.dmem_addr == ADDR_LEN'(8));
    // Full is sampled before any same-edge pop, so a write into a full queue drops.
    assign push  = cw && !q_full;

    logic unused_wdata;
    assign unused_wdata = ^bus.dmem_wdata[DATA_LEN-1:8];

`ifdef MMIO_UART_TX_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    logic [PW:0] wptr_q, wptr_d;
    logic [PW:0] rptr_q, rptr_d;
    logic [7:0]  mem_q [FIFO_DEPTH];

    assign q_empty = (wptr_q == rptr_q);
    assign q_full  = (wptr_q[PW] != rptr_q[PW]) &&
                     (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign q_head  = mem_q[rptr_q[PW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) wptr_d = wptr_q + PTR_ONE;
        if (pop)  rptr_d = rptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[PW-1:0]] <= wbyte;
    end
`else
    logic       hold_vld_q, hold_vld_d;
    logic [7:0] hold_q, hold_d;

    logic unused_cfg;
    assign unused_cfg = ^32'(FIFO_DEPTH);

    assign q_empty = !hold_vld_q;
    assign q_full  = hold_vld_q;
    assign q_head  = hold_q;

    always_comb begin
        hold_vld_d = hold_vld_q;
        hold_d     = hold_q;
        if (pop) hold_vld_d = 1'b0;
        if (push) begin
            hold_vld_d = 1'b1;
            hold_d     = wbyte;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            hold_vld_q <= hold_vld_d;
            hold_q     <= hold_d;
        end
    end
`endif

    state_t     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       txd_q, txd_d;
    logic       baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!q_empty) begin
                    pop     = 1'b1;
                    shift_d = q_head;
                    bit_d   = '0;
                    baud_d  = '0;
                    txd_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    txd_d   = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit with no idle gap.
                    if (!q_empty) begin
                        pop     = 1'b1;
                        shift_d = q_head;
                        bit_d   = '0;
                        txd_d   = 1'b0;
                        state_d = S_START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    logic [7:0] led_q, led_d;
    logic       fin_q, fin_d;
    logic       ovf_q, ovf_d;

    always_comb begin
        led_d = led_q;
        if (push) led_d = {led_q[7], wbyte[6:0]};
        if (fw)   led_d[7] = 1'b1;
        fin_d = fin_q | fw;
        ovf_d = ovf_q | (cw && q_full);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q <= '0;
            fin_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            led_q <= led_d;
            fin_q <= fin_d;
            ovf_q <= ovf_d;
        end
    end

    assign txd      = txd_q;
    assign led      = led_q;
    assign finished = fin_q;
    assign overflow = ovf_q;
    assign done     = fin_q && q_empty && (state_q == S_IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLK_DIV=4, FIFO_DEPTH=16.
// Expectations follow whichever queue build (FIFO or holding register) is compiled.
module tb_mmio_uart_tx;

`ifdef MMIO_UART_TX_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif
    localparam int DIV = 4;
    localparam int FRM = 10 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       txd;
    logic [7:0] led;
    logic       finished;
    logic       done;
    logic       overflow;

    mmio_uart_tx_if #(.ADDR_LEN(32), .DATA_LEN(32)) bus ();

    mmio_uart_tx #(
        .CLK_DIV(DIV),
        .FIFO_DEPTH(16),
        .ADDR_LEN(32),
        .DATA_LEN(32)
    ) dut (
        .clk(clk),
        .reset(rst),
        .bus(bus),
        .txd(txd),
        .led(led),
        .finished(finished),
        .done(done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_b;
    bit         rx_ok;
    int         rx_t0;

    // Receiver: sample at negedges; abandon a frame if reset is seen.
    always begin
        @(negedge clk);
        if (!rst && txd == 1'b0) begin
            rx_ok = 1'b1;
            rx_t0 = cyc;
            for (int k = 1; k <= 9 * DIV; k++) begin
                @(negedge clk);
                if (rst) rx_ok = 1'b0;
                if (k % DIV == 0 && k <= 8 * DIV) rx_b[k/DIV-1] = txd;
            end
            if (rx_ok && txd == 1'b1) begin
                rx_q.push_back(rx_b);
                rx_t.push_back(rx_t0);
            end else if (rx_ok) begin
                rx_q.push_back(8'hEE);
                rx_t.push_back(rx_t0);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.dmem_we    = 1'b1;
        bus.dmem_addr  = a;
        bus.dmem_wdata = d;
        tick();
        bus.dmem_we    = 1'b0;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        tick();
        rx_q.delete();
        rx_t.delete();
        exp_q.delete();
    endtask

    task automatic chk_rx(input string nm, input bit gaps);
        int n;
        chk({nm, "_nframes"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_frame%0d", nm, i), rx_q[i], exp_q[i]);
            if (gaps && i > 0)
                chk($sformatf("%s_gap%0d", nm, i), rx_t[i] - rx_t[i-1], FRM);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  led;
        logic        fin;
        logic        ovf;
    } vec_t;

    vec_t tbl[8];
    logic [9:0] fr;
    int rise;
    int hi;

    initial begin
        bus.dmem_we    = 1'b0;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;

        tbl[0] = '{32'h4,  32'hFF, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{32'h0,  32'h55, 8'h55, 1'b0, 1'b0};
        tbl[2] = '{32'hC,  32'h12, 8'h55, 1'b0, 1'b0};
        tbl[3] = '{32'h0,  32'hC1, 8'h41, 1'b0, 1'b0};
        tbl[4] = '{32'h8,  32'h00, 8'hC1, 1'b1, 1'b0};
        tbl[5] = '{32'h8,  32'h01, 8'hC1, 1'b1, 1'b0};
        tbl[6] = '{32'h0,  32'h7E, FIFO_EN ? 8'hFE : 8'hC1, 1'b1, !FIFO_EN};
        tbl[7] = '{32'h10, 32'h33, FIFO_EN ? 8'hFE : 8'hC1, 1'b1, !FIFO_EN};

        // Reset values
        tick();
        chk("rst_txd", txd, 1);
        chk("rst_led", led, 0);
        chk("rst_fin", finished, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_done", done, 0);
        do_reset();

        // Single char, cycle-exact frame
        store(32'h0, 32'h55);
        chk("t1_led", led, 8'h55);
        chk("t1_txd_e0", txd, 1);
        fr = {1'b1, 8'h55, 1'b0};
        for (int k = 1; k <= FRM; k++) begin
            tick();
            chk($sformatf("t1_txd_c%0d", k), txd, fr[(k-1)/DIV]);
        end
        tick();
        chk("t1_txd_idle", txd, 1);
        chk("t1_done", done, 0);
        exp_q.push_back(8'h55);
        chk_rx("t1", 1'b0);

        // Register-effect vectors, including ignored addresses
        do_reset();
        for (int i = 0; i < 8; i++) begin
            store(tbl[i].addr, tbl[i].data);
            chk($sformatf("tbl%0d_led", i), led, tbl[i].led);
            chk($sformatf("tbl%0d_fin", i), finished, tbl[i].fin);
            chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].ovf);
        end
        wait_cyc(4 * FRM);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hC1);
        if (FIFO_EN) exp_q.push_back(8'h7E);
        chk_rx("tbl", 1'b0);
        chk("tbl_done", done, 1);

        // Three consecutive chars, contiguous frames
        do_reset();
        store(32'h0, 32'h41);
        store(32'h0, 32'h42);
        store(32'h0, 32'h43);
        chk("t3_led", led, 8'h43);
        chk("t3_ovf", overflow, !FIFO_EN);
        wait_cyc(4 * FRM);
        exp_q.push_back(8'h41);
        if (FIFO_EN) exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        chk_rx("t3", 1'b1);
        chk("t3_txd_idle", txd, 1);

        // Overflow: 18 writes 0x00..0x11
        do_reset();
        for (int i = 0; i < 18; i++) store(32'h0, 32'(i));
        chk("t4_ovf", overflow, 1);
        chk("t4_led", led, FIFO_EN ? 8'h10 : 8'h02);
        wait_cyc(18 * FRM);
        if (FIFO_EN) begin
            for (int i = 0; i < 17; i++) exp_q.push_back(8'(i));
        end else begin
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h02);
        end
        chk_rx("t4", 1'b1);

        // Finish with pending data; done timing
        do_reset();
        store(32'h0, 32'h30);
        store(32'h0, 32'h31);
        chk("t5_done_pre", done, 0);
        store(32'h8, 32'h0);
        chk("t5_fin", finished, 1);
        chk("t5_led", led, FIFO_EN ? 8'hB1 : 8'hB0);
        chk("t5_done_busy", done, 0);
        rise = 0;
        for (int k = 3; k <= 200; k++) begin
            tick();
            if (done) begin
                rise = k;
                break;
            end
        end
        chk("t5_done_rise", rise, FIFO_EN ? 81 : 41);
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) hi++;
        end
        chk("t5_done_sticky", hi, 20);
        exp_q.push_back(8'h30);
        if (FIFO_EN) exp_q.push_back(8'h31);
        chk_rx("t5", 1'b1);

        // Reset mid-frame during DATA bit 3 of 0x5A
        do_reset();
        store(32'h0, 32'h5A);
        store(32'h0, 32'h11);
        store(32'h0, 32'h22);
        wait_cyc(16);
        chk("t6_txd_bit3", txd, 1);
        rst = 1'b1;
        #1;
        chk("t6_txd", txd, 1);
        chk("t6_led", led, 0);
        chk("t6_fin", finished, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_done", done, 0);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(100);
        rx_q.delete();
        rx_t.delete();
        wait_cyc(60);
        chk("t6_silent", rx_q.size(), 0);
        store(32'h0, 32'h01);
        chk("t6_led_new", led, 8'h01);
        wait_cyc(FRM + 10);
        exp_q.delete();
        exp_q.push_back(8'h01);
        chk_rx("t6", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
